// File: rtl/flash_burst_reader.sv
// Burst read engine for a parallel NOR flash: fetches BEATS consecutive bus words
// with page-hit/page-miss access timing and returns them packed little-endian.
module flash_burst_reader #(
  parameter int BUS_WIDTH = 8,
  parameter int BEATS     = 2,
  parameter int ROM_ADDR  = 24,
  parameter int PAGE_BITS = 4,
  parameter int T_MISS    = 4,
  parameter int T_HIT     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ROM_ADDR-1:0]          req_addr,
  input  logic                         invalidate,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [BEATS*BUS_WIDTH-1:0]   rsp_data,
  output logic [BEATS-1:0]             rsp_hits,
  input  logic [BUS_WIDTH-1:0]         SF_D,
  output logic [ROM_ADDR-1:0]          SF_A,
  output logic                         SF_CE0,
  output logic                         SF_OE,
  output logic                         SF_WE,
  output logic                         SF_BYTE
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(T_MISS + 1);
  localparam int TAG_W  = ROM_ADDR - PAGE_BITS;
  localparam logic [ROM_ADDR-1:0] STEP = ROM_ADDR'(BUS_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state_reg;
  logic                 req_ready_reg;
  logic                 rsp_valid_reg;
  logic [BEATS-1:0]     rsp_hits_reg;
  logic [ROM_ADDR-1:0]  sf_a_reg;
  logic [BEAT_W-1:0]    beat_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     wait_reg;
  logic [TAG_W-1:0]     open_tag_reg;
  logic                 page_valid_reg;
  logic [BUS_WIDTH-1:0] slot_reg [BEATS];

  logic [ROM_ADDR-1:0]  addr_next;
  logic [TAG_W-1:0]     tag_next;
  logic                 hit_next;
  logic                 sample;
  logic                 last_beat;
  logic [BEAT_W-1:0]    beat_inc;

  // Address of the beat that would start on this edge: the request in IDLE,
  // otherwise the next sequential bus word (wrapping at the top of the flash).
  assign addr_next = (state_reg == IDLE) ? req_addr : sf_a_reg + STEP;
  assign tag_next  = addr_next[ROM_ADDR-1:PAGE_BITS];
  assign hit_next  = page_valid_reg && (tag_next == open_tag_reg) && !invalidate;
  assign sample    = (state_reg == WAIT) && (cnt_reg == wait_reg - CNT_W'(1));
  assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));
  assign beat_inc  = beat_reg + BEAT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_hits_reg   <= '0;
      sf_a_reg       <= '0;
      beat_reg       <= '0;
      cnt_reg        <= '0;
      wait_reg       <= '0;
      open_tag_reg   <= '0;
      page_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (invalidate) page_valid_reg <= 1'b0;
          if (req_valid && req_ready_reg) begin
            req_ready_reg  <= 1'b0;
            sf_a_reg       <= addr_next;
            beat_reg       <= '0;
            cnt_reg        <= '0;
            wait_reg       <= hit_next ? CNT_W'(T_HIT) : CNT_W'(T_MISS);
            rsp_hits_reg   <= BEATS'(hit_next);
            open_tag_reg   <= tag_next;
            page_valid_reg <= 1'b1;
            state_reg      <= WAIT;
          end else begin
            req_ready_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (sample && last_beat) begin
            if (invalidate) page_valid_reg <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else if (sample) begin
            // Next beat starts here; its timing is decided on this edge.
            beat_reg               <= beat_inc;
            sf_a_reg               <= addr_next;
            cnt_reg                <= '0;
            wait_reg               <= hit_next ? CNT_W'(T_HIT) : CNT_W'(T_MISS);
            rsp_hits_reg[beat_inc] <= hit_next;
            open_tag_reg           <= tag_next;
            page_valid_reg         <= 1'b1;
          end else begin
            if (invalidate) page_valid_reg <= 1'b0;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESP: begin
          if (invalidate) page_valid_reg <= 1'b0;
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_reg[gi] <= '0;
        end else if (sample && (beat_reg == BEAT_W'(gi))) begin
          slot_reg[gi] <= SF_D;
        end
      end
      assign rsp_data[gi*BUS_WIDTH +: BUS_WIDTH] = slot_reg[gi];
    end
  endgenerate

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_hits  = rsp_hits_reg;
  assign SF_A      = sf_a_reg;
  assign SF_CE0    = 1'b0;
  assign SF_OE     = 1'b0;
  assign SF_WE     = 1'b1;
  assign SF_BYTE   = (BUS_WIDTH == 16);

endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench for flash_burst_reader (BUS_WIDTH=8, BEATS=2, T_MISS=4, T_HIT=2)
// with a combinational flash model driving SF_D from SF_A.
module tb_flash_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic        invalidate = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_hits;
  logic [7:0]  SF_D;
  logic [23:0] SF_A;
  logic        SF_CE0, SF_OE, SF_WE, SF_BYTE;

  int checks = 0;
  int fails  = 0;

  flash_burst_reader dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .invalidate(invalidate),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hits(rsp_hits),
    .SF_D(SF_D), .SF_A(SF_A), .SF_CE0(SF_CE0), .SF_OE(SF_OE), .SF_WE(SF_WE), .SF_BYTE(SF_BYTE)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [23:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd7;
    return t ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h3C;
  endfunction

  assign SF_D = mem(SF_A);

  function automatic logic [15:0] pair(input logic [23:0] a);
    logic [23:0] a1;
    a1 = a + 24'd1;
    return {mem(a1), mem(a)};
  endfunction

  // Issues one request and counts edges from acceptance to rsp_valid.
  // invalidate is held high for the edge numbered inv_edge after acceptance.
  task automatic issue(input logic [23:0] addr, input int inv_edge, output int lat);
    @(negedge clk);
    req_addr  = addr;
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_req_ready addr=%h got=%b want=1", addr, req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      invalidate = (lat + 1 == inv_edge);
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid === 1'b1) break;
    end
    invalidate = 1'b0;
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks += 6;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    if (rsp_data !== 16'h0) begin fails++; $display("FAIL rst_rsp_data got=%h want=0000", rsp_data); end
    if (rsp_hits !== 2'b00) begin fails++; $display("FAIL rst_rsp_hits got=%b want=00", rsp_hits); end
    if (SF_A !== 24'h0)     begin fails++; $display("FAIL rst_sf_a got=%h want=000000", SF_A); end
    if ({SF_CE0, SF_OE, SF_WE, SF_BYTE} !== 4'b0010) begin
      fails++; $display("FAIL rst_ties got=%b want=0010", {SF_CE0, SF_OE, SF_WE, SF_BYTE});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL rel_req_ready_early got=%b want=0", req_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rel_req_ready got=%b want=1", req_ready); end
    $display("reset: outputs cleared, req_ready rises one edge after release");
  endtask

  task automatic test_burst(input string name, input logic [23:0] addr, input int inv_edge,
                            input logic [1:0] exp_hits, input int exp_lat);
    int lat;
    logic [15:0] exp_data;
    exp_data = pair(addr);
    issue(addr, inv_edge, lat);
    checks += 3;
    if (lat !== exp_lat) begin
      fails++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
    end
    if (rsp_data !== exp_data) begin
      fails++; $display("FAIL %s_data got=%h want=%h", name, rsp_data, exp_data);
    end
    if (rsp_hits !== exp_hits) begin
      fails++; $display("FAIL %s_hits got=%b want=%b", name, rsp_hits, exp_hits);
    end
    take_rsp();
    checks += 2;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL %s_rsp_drop got=%b want=0", name, rsp_valid); end
    if (req_ready !== 1'b1) begin fails++; $display("FAIL %s_req_ready got=%b want=1", name, req_ready); end
    $display("%s: addr=%h lat=%0d data=%h hits=%b", name, addr, lat, rsp_data, rsp_hits);
  endtask

  task automatic test_invalidate_idle();
    @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] exp_data;
    exp_data = pair(24'h000004);
    issue(24'h000004, -1, lat);
    checks += 2;
    if (lat !== 4) begin fails++; $display("FAIL hold_latency got=%0d want=4", lat); end
    if (rsp_hits !== 2'b11) begin fails++; $display("FAIL hold_hits got=%b want=11", rsp_hits); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 24'h000040;
      checks += 3;
      if (rsp_valid !== 1'b1) begin fails++; $display("FAIL hold_valid_%0d got=%b want=1", i, rsp_valid); end
      if (rsp_data !== exp_data) begin fails++; $display("FAIL hold_data_%0d got=%h want=%h", i, rsp_data, exp_data); end
      if (req_ready !== 1'b0) begin fails++; $display("FAIL hold_req_ready_%0d got=%b want=0", i, req_ready); end
    end
    @(negedge clk);
    req_valid = 1'b0;
    take_rsp();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL hold_ignored got=%b want=0", rsp_valid); end
    $display("hold: response held 5 cycles, data=%h, ignored request dropped", rsp_data);
    test_invalidate_idle();
    test_burst("inval_reuse", 24'h000006, -1, 2'b10, 6);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    req_addr  = 24'h000006;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 3;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL abort_rsp_valid got=%b want=0", rsp_valid); end
    if (req_ready !== 1'b0) begin fails++; $display("FAIL abort_req_ready got=%b want=0", req_ready); end
    if (SF_A !== 24'h0) begin fails++; $display("FAIL abort_sf_a got=%h want=000000", SF_A); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_rel_ready got=%b want=1", req_ready); end
    $display("abort: reset mid-burst cleared outputs");
    test_burst("after_abort", 24'h000006, -1, 2'b10, 6);
  endtask

  initial begin
    test_reset();
    test_burst("first_miss", 24'h000010, -1, 2'b10, 6);
    test_burst("back_to_back", 24'h000012, -1, 2'b11, 4);
    test_burst("inval_midbeat", 24'h000014, 1, 2'b01, 6);
    test_invalidate_idle();
    test_burst("page_cross", 24'h00001F, -1, 2'b00, 8);
    test_burst("addr_wrap", 24'hFFFFFF, -1, 2'b00, 8);
    test_backpressure();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
